ni_tx: RTL and testbench

Synchronous network-interface transmitter that injects packets into the local input port of an asynchronous SDM router. It accepts a packet descriptor and a payload stream on a clocked valid/ready interface. It encodes the head flit (destination x/y in 1-of-4 digits) and the payload flits into 1-of-4 dual-rail groups with a one-hot flit type and one-hot VC, and drives them with a 4-phase return-to-zero handshake. It is the sending end of the per-port routing/input-buffer interface.

---
 rtl/ni_tx.sv | 159 +++++++++++++++
 tb/tb_ni_tx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_tx.sv
// ni_tx: clocked packet source that drives 1-of-4 dual-rail flits (head + payload) into the
// local input port of an asynchronous router using a 4-phase return-to-zero handshake.
module ni_tx #(
    parameter int unsigned VCN = 2,
    parameter int unsigned DW  = 8,
    parameter int unsigned LW  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pkt_req,
    output logic              pkt_ack,
    input  logic [3:0]        pkt_dx,
    input  logic [3:0]        pkt_dy,
    input  logic [VCN-1:0]    pkt_vc,
    input  logic [LW-1:0]     pkt_nb,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DW-1:0]     pl_data,
    output logic [DW/2-1:0]   do0,
    output logic [DW/2-1:0]   do1,
    output logic [DW/2-1:0]   do2,
    output logic [DW/2-1:0]   do3,
    output logic [2:0]        dot,
    output logic [VCN-1:0]    dovc,
    input  logic              doa,
    output logic              busy
);

    localparam int unsigned NG = DW / 2;

    typedef enum logic [2:0] {
        StIdle,
        StHset,
        StHrtz,
        StPwait,
        StPset,
        StPrtz
    } state_e;

    state_e                 state_q, state_d;
    logic [LW-1:0]          cnt_q, cnt_d;
    logic [VCN-1:0]         vc_q, vc_d;
    logic [3:0][NG-1:0]     rail_q, rail_d;
    logic [2:0]             dot_q, dot_d;
    logic [VCN-1:0]         dovc_q, dovc_d;
    logic                   doa_m_q, doa_s_q;
    logic [1:0]             arm_q;
    logic [DW-1:0]          head_w;

    // Rail k of a word: bit g is set when group g of the word holds value k.
    function automatic logic [NG-1:0] rail_of(input logic [DW-1:0] w, input logic [1:0] k);
        logic [NG-1:0] r;
        for (int g = 0; g < int'(NG); g++) begin
            r[g] = (w[2*g +: 2] == k);
        end
        return r;
    endfunction

    always_comb begin
        head_w      = '0;
        head_w[7:0] = {pkt_dy, pkt_dx};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vc_d     = vc_q;
        rail_d   = rail_q;
        dot_d    = dot_q;
        dovc_d   = dovc_q;
        pkt_ack  = 1'b0;
        pl_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                // arm_q keeps a stale acknowledge from slipping past the freshly reset synchronizer.
                pkt_ack = rstn & pkt_req & ~doa_s_q & arm_q[1];
                if (pkt_ack) begin
                    cnt_d  = pkt_nb;
                    vc_d   = pkt_vc;
                    for (int k = 0; k < 4; k++) begin
                        rail_d[k] = rail_of(head_w, 2'(k));
                    end
                    dot_d   = 3'b001;
                    dovc_d  = pkt_vc;
                    state_d = StHset;
                end
            end
            StHset, StPset: begin
                if (doa_s_q) begin
                    rail_d  = '0;
                    dot_d   = '0;
                    dovc_d  = '0;
                    state_d = (state_q == StHset) ? StHrtz : StPrtz;
                end
            end
            StHrtz: begin
                if (!doa_s_q) begin
                    state_d = StPwait;
                end
            end
            StPwait: begin
                pl_ready = rstn;
                if (pl_valid) begin
                    for (int k = 0; k < 4; k++) begin
                        rail_d[k] = rail_of(pl_data, 2'(k));
                    end
                    dot_d   = (cnt_q == '0) ? 3'b100 : 3'b010;
                    dovc_d  = vc_q;
                    state_d = StPset;
                end
            end
            StPrtz: begin
                if (!doa_s_q) begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q - LW'(1);
                        state_d = StPwait;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            vc_q    <= '0;
            rail_q  <= '0;
            dot_q   <= '0;
            dovc_q  <= '0;
            doa_m_q <= 1'b0;
            doa_s_q <= 1'b0;
            arm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vc_q    <= vc_d;
            rail_q  <= rail_d;
            dot_q   <= dot_d;
            dovc_q  <= dovc_d;
            doa_m_q <= doa;
            doa_s_q <= doa_m_q;
            arm_q   <= {arm_q[0], 1'b1};
        end
    end

    assign do0  = rail_q[0];
    assign do1  = rail_q[1];
    assign do2  = rail_q[2];
    assign do3  = rail_q[3];
    assign dot  = dot_q;
    assign dovc = dovc_q;
    assign busy = rstn & (state_q != StIdle);

endmodule

// File: tb/tb_ni_tx.sv
// Bench for ni_tx: table-driven single-flit packets, hand sequences for the handshake corner
// cases, and randomized packets against a flit-level scoreboard with an echoing router model.
module tb_ni_tx;

    localparam int VCN = 2;
    localparam int DW  = 8;
    localparam int LW  = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           pkt_req = 1'b0;
    logic           pkt_ack;
    logic [3:0]     pkt_dx = '0;
    logic [3:0]     pkt_dy = '0;
    logic [VCN-1:0] pkt_vc = '0;
    logic [LW-1:0]  pkt_nb = '0;
    logic           pl_valid = 1'b0;
    logic           pl_ready;
    logic [DW-1:0]  pl_data = '0;
    logic [3:0]     do0, do1, do2, do3;
    logic [2:0]     dot;
    logic [VCN-1:0] dovc;
    logic           doa;
    logic           busy;

    always #5 clk = ~clk;

    ni_tx #(.VCN(VCN), .DW(DW), .LW(LW)) dut (
        .clk(clk), .rstn(rstn), .pkt_req(pkt_req), .pkt_ack(pkt_ack), .pkt_dx(pkt_dx),
        .pkt_dy(pkt_dy), .pkt_vc(pkt_vc), .pkt_nb(pkt_nb), .pl_valid(pl_valid),
        .pl_ready(pl_ready), .pl_data(pl_data), .do0(do0), .do1(do1), .do2(do2), .do3(do3),
        .dot(dot), .dovc(dovc), .doa(doa), .busy(busy)
    );

    typedef struct {
        logic [15:0] rails;
        logic [2:0]  dot;
        logic [1:0]  vc;
        int          cyc;
    } flit_t;

    typedef struct {
        logic [3:0]  dx;
        logic [3:0]  dy;
        logic [1:0]  vc;
        logic [7:0]  pl;
        logic [15:0] head_r;
        logic [15:0] pl_r;
    } vec_t;

    flit_t      got_q[$];
    flit_t      exp_q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         busy_fall_cyc = 0;
    int         rdy_cnt = 0;
    int         dly = 0;
    int         gap_max = 0;
    logic       force_hi = 1'b0;
    logic [7:0] hist = '0;
    logic       prev_nz = 1'b0;
    logic       prev_busy = 1'b0;
    logic [20:0] prev_word = '0;
    logic       m_m = 1'b0, s_m = 1'b0, s_before = 1'b0, rst_at_edge = 1'b1;
    logic [7:0] pl_buf[16];

    // Router model: acknowledge follows "any rail high" after dly extra cycles.
    assign doa = force_hi | hist[dly];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [15:0] model_rails(input logic [7:0] w);
        logic [15:0] r = '0;
        for (int g = 0; g < 4; g++) begin
            int v = (int'(w) >> (2 * g)) % 4;
            r[v * 4 + g] = 1'b1;
        end
        return r;
    endfunction

    // Two-flop synchronizer as seen from outside, used to judge when a rail may drop.
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !rstn;
        s_before    <= s_m;
        m_m         <= rstn ? doa : 1'b0;
        s_m         <= rstn ? m_m : 1'b0;
    end

    always @(negedge clk) begin
        logic [15:0] r;
        logic        ok;
        r  = {do3, do2, do1, do0};
        ok = 1'b1;
        for (int g = 0; g < 4; g++) begin
            if ($countones({r[g], r[4+g], r[8+g], r[12+g]}) > 1) ok = 1'b0;
        end
        check("group_onehot", 32'(ok), 1);
        check("dot_onehot0", 32'($onehot0(dot)), 1);
        check("ready_only_when_busy", 32'(pl_ready & ~busy), 0);
        if (|r && prev_nz) check("rail_hold", {r, dot, dovc}, prev_word);
        if (|r && !prev_nz) got_q.push_back('{r, dot, dovc, cyc});
        if (!(|r) && prev_nz && !rst_at_edge) check("rail_drop_before_ack", 32'(s_before), 1);
        if (prev_busy && !busy) busy_fall_cyc <= cyc;
        if (pl_ready) rdy_cnt <= rdy_cnt + 1;
        prev_nz   <= |r;
        prev_word <= {r, dot, dovc};
        prev_busy <= busy;
        hist      <= {hist[6:0], |r};
    end

    task automatic expect_pkt(input logic [3:0] dx, input logic [3:0] dy, input logic [1:0] vc,
                              input logic [3:0] nb);
        exp_q.push_back('{model_rails({dy, dx}), 3'b001, vc, 0});
        for (int i = 0; i <= int'(nb); i++) begin
            exp_q.push_back('{model_rails(pl_buf[i]), (i == int'(nb)) ? 3'b100 : 3'b010, vc, 0});
        end
    endtask

    task automatic req_phase(input logic [3:0] dx, input logic [3:0] dy, input logic [1:0] vc,
                             input logic [3:0] nb);
        int n = 0;
        expect_pkt(dx, dy, vc, nb);
        @(negedge clk);
        pkt_req = 1'b1; pkt_dx = dx; pkt_dy = dy; pkt_vc = vc; pkt_nb = nb;
        #1;
        while (!pkt_ack) begin
            @(negedge clk); #1; n++;
            if (n > 300) begin check("ack_timeout", 0, 1); pkt_req = 1'b0; return; end
        end
        @(posedge clk);
        @(negedge clk);
        pkt_req = 1'b0;
        pkt_dx = 4'($urandom); pkt_dy = 4'($urandom); pkt_vc = 2'($urandom);
        pkt_nb = 4'($urandom);
    endtask

    task automatic pl_phase(input logic [3:0] nb);
        int n;
        for (int i = 0; i <= int'(nb); i++) begin
            if (gap_max > 0) begin
                pl_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
            end
            pl_valid = 1'b1; pl_data = pl_buf[i];
            #1; n = 0;
            while (!pl_ready) begin
                @(negedge clk); #1; n++;
                if (n > 300) begin check("ready_timeout", 0, 1); pl_valid = 1'b0; return; end
            end
            @(posedge clk);
            @(negedge clk);
            pl_valid = 1'b0; pl_data = 8'($urandom);
        end
        #1; n = 0;
        while (busy) begin
            @(negedge clk); #1; n++;
            if (n > 300) begin check("busy_timeout", 0, 1); return; end
        end
    endtask

    task automatic send_pkt(input logic [3:0] dx, input logic [3:0] dy, input logic [1:0] vc,
                            input logic [3:0] nb);
        req_phase(dx, dy, vc, nb);
        pl_phase(nb);
    endtask

    task automatic compare_flits(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check(name, {got_q[i].rails, got_q[i].dot, got_q[i].vc},
                  {exp_q[i].rails, exp_q[i].dot, exp_q[i].vc});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t vecs[4];
        int   c, base, n;
        logic ok, ack_seen;
        logic [3:0] nb;

        vecs[0] = '{4'b0110, 4'b1001, 2'b01, 8'hE4, 16'b0000_1001_0110_0000,
                    16'b1000_0100_0010_0001};
        vecs[1] = '{4'b0000, 4'b1111, 2'b10, 8'h1B, 16'b1100_0000_0000_0011,
                    16'b0001_0010_0100_1000};
        vecs[2] = '{4'b1101, 4'b0010, 2'b01, 8'hA5, 16'b0010_0100_0001_1000,
                    16'b0000_1100_0011_0000};
        vecs[3] = '{4'b1011, 4'b0100, 2'b10, 8'hFF, 16'b0001_0010_1000_0100,
                    16'b1111_0000_0000_0000};

        // Reset state, with a request already pending.
        pkt_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_rails", {do3, do2, do1, do0, dot, dovc}, 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_ack", 32'(pkt_ack), 0);
        check("reset_ready", 32'(pl_ready), 0);
        pkt_req = 1'b0;
        rstn = 1'b1;

        // Table: single-payload packets with hand-encoded codewords and timing.
        for (int v = 0; v < 4; v++) begin
            pl_buf[0] = vecs[v].pl;
            send_pkt(vecs[v].dx, vecs[v].dy, vecs[v].vc, 4'd0);
            check("tbl_flits", got_q.size(), 2);
            if (got_q.size() == 2) begin
                check("tbl_head_rails", got_q[0].rails, vecs[v].head_r);
                check("tbl_head_dot", got_q[0].dot, 3'b001);
                check("tbl_head_vc", got_q[0].vc, vecs[v].vc);
                check("tbl_pl_rails", got_q[1].rails, vecs[v].pl_r);
                check("tbl_pl_dot", got_q[1].dot, 3'b100);
                check("tbl_pl_vc", got_q[1].vc, vecs[v].vc);
                check("tbl_flit_spacing", got_q[1].cyc - got_q[0].cyc, 7);
                check("tbl_busy_fall", busy_fall_cyc - got_q[0].cyc, 13);
            end
            got_q.delete();
            exp_q.delete();
        end

        // Four payloads: three body flits then tail, one ready cycle per flit.
        pl_buf[0] = 8'hA5; pl_buf[1] = 8'h5A; pl_buf[2] = 8'hFF; pl_buf[3] = 8'h00;
        base = rdy_cnt;
        send_pkt(4'h9, 4'h6, 2'b10, 4'd3);
        check("nb3_ready_cycles", rdy_cnt - base, 4);
        if (got_q.size() == 5) begin
            for (int i = 1; i < 5; i++) check("nb3_spacing", got_q[i].cyc - got_q[i-1].cyc, 7);
            check("nb3_busy_fall", busy_fall_cyc - got_q[0].cyc, 34);
        end
        compare_flits("nb3");

        // Payload stall in PWAIT.
        pl_buf[0] = 8'h3C;
        req_phase(4'h3, 4'hC, 2'b10, 4'd0);
        #1; n = 0;
        while (!pl_ready && n < 300) begin @(negedge clk); #1; n++; end
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!(pl_ready === 1'b1 && {do3, do2, do1, do0} === 16'h0)) ok = 1'b0;
            @(negedge clk); #1;
        end
        check("stall_ready_rails_zero", 32'(ok), 1);
        pl_valid = 1'b1; pl_data = pl_buf[0]; c = cyc;
        @(posedge clk);
        @(negedge clk);
        pl_valid = 1'b0;
        n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        if (got_q.size() >= 2) check("stall_resume_launch", got_q[1].cyc, c + 1);
        compare_flits("stall");

        // Acknowledge held high across reset: no head until it falls, then 3 edges later.
        force_hi = 1'b1;
        @(negedge clk); rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        pkt_req = 1'b1; pkt_dx = 4'h5; pkt_dy = 4'hA; pkt_vc = 2'b01; pkt_nb = 4'd0;
        ack_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            ack_seen |= pkt_ack;
        end
        check("stale_ack_no_accept", 32'(ack_seen), 0);
        check("stale_ack_no_launch", got_q.size(), 0);
        force_hi = 1'b0;
        c = cyc;
        pl_buf[0] = 8'h96;
        send_pkt(4'h5, 4'hA, 2'b01, 4'd0);
        if (got_q.size() >= 1) check("stale_ack_launch_delay", got_q[0].cyc, c + 3);
        compare_flits("stale");

        // Reset during PSET of a body flit, then a fresh packet.
        pl_buf[0] = 8'h11;
        @(negedge clk);
        pkt_req = 1'b1; pkt_dx = 4'h2; pkt_dy = 4'h7; pkt_vc = 2'b10; pkt_nb = 4'd2;
        #1; n = 0;
        while (!pkt_ack && n < 300) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        @(negedge clk);
        pkt_req = 1'b0; pl_valid = 1'b1; pl_data = pl_buf[0];
        n = 0;
        while (got_q.size() < 2 && n < 300) begin @(negedge clk); n++; end
        #1;
        check("abort_body_dot", got_q.size() >= 2 ? got_q[1].dot : 3'b000, 3'b010);
        rstn = 1'b0; pl_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_rails_zero", {do3, do2, do1, do0, dot, dovc}, 0);
        check("abort_ready", 32'(pl_ready), 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("abort_idle", 32'(busy), 0);
        got_q.delete();
        exp_q.delete();
        pl_buf[0] = 8'hC3; pl_buf[1] = 8'h7E;
        send_pkt(4'hE, 4'h1, 2'b01, 4'd1);
        compare_flits("after_abort");

        // Randomized packets with late acknowledges and payload gaps.
        for (int p = 0; p < 24; p++) begin
            dly     = $urandom_range(0, 3);
            gap_max = $urandom_range(0, 2);
            nb      = 4'($urandom_range(0, 3));
            for (int i = 0; i <= int'(nb); i++) pl_buf[i] = 8'($urandom);
            send_pkt(4'($urandom), 4'($urandom), 2'(1 << $urandom_range(0, 1)), nb);
        end
        compare_flits("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
